// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared encodings and alignment helpers for the fetch PC (macro PC_COMPRESSED_EN)
package pc_pkg;

   // Program-counter FSM encodings, also driven out on pc_state.
   localparam logic [1:0] PC_BOOT = 2'd0;
   localparam logic [1:0] PC_RUN  = 2'd1;
   localparam logic [1:0] PC_HALT = 2'd2;

   // Sequential increments for full-width and compressed instructions.
   localparam logic [2:0] STEP_WORD = 3'd4;
   localparam logic [2:0] STEP_HALF = 3'd2;

   // Low-order address bits that must be zero for a legal fetch target.
`ifdef PC_COMPRESSED_EN
   localparam logic [1:0] ALIGN_MASK = 2'b01;
`else
   localparam logic [1:0] ALIGN_MASK = 2'b11;
`endif

   // Decision taken by the next-PC selector in RUN; at most one bit is set.
   typedef struct packed {
      logic take_trap;
      logic take_redirect;
      logic reject_redirect;
      logic advance;
   } pc_sel_t;

   // True when the low bits of an address violate the fetch alignment.
   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return |(low_bits & ALIGN_MASK);
   endfunction

   // Force the alignment bits of an address to zero.
   function automatic logic [1:0] clear_align(input logic [1:0] low_bits);
      return low_bits & ~ALIGN_MASK;
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC priority mux, handshake and misalign check
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      i_state,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_stall,
   input  logic            i_fetch_ready,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_target,
   input  logic            i_trap_valid,
   input  logic [XLEN-1:0] i_trap_vector,
   input  logic            i_halt_req,
   input  logic            i_resume,
   input  logic            i_is_c,
   output logic            o_fetch_valid,
   output logic            o_accept,
   output logic [XLEN-1:0] o_next_pc,
   output logic [1:0]      o_next_state,
   output logic            o_misalign
);

   logic [XLEN-1:0] w_trap_pc;
   logic [XLEN-1:0] w_seq_pc;
   logic [2:0]      w_step;
   logic            w_redir_bad;
   pc_sel_t         w_sel;

   // Trap entry address with its alignment bits stripped.
   assign w_trap_pc   = {i_trap_vector[XLEN-1:2], clear_align(i_trap_vector[1:0])};
   assign w_redir_bad = is_misaligned(i_redirect_target[1:0]);

   // Sequential successor; the adder simply wraps at 2^XLEN.
   assign w_step   = i_is_c ? STEP_HALF : STEP_WORD;
   assign w_seq_pc = i_pc + XLEN'(w_step);

   // A request is only offered while running and not held by the hazard unit.
   assign o_fetch_valid = (i_state == PC_RUN) && !i_stall;
   assign o_accept      = o_fetch_valid && i_fetch_ready;

   // Priority decision for RUN: trap, then redirect (good or bad), then advance.
   always_comb begin
      w_sel = '0;
      if (i_trap_valid) begin
         w_sel.take_trap = 1'b1;
      end else if (i_redirect_valid && !w_redir_bad) begin
         w_sel.take_redirect = 1'b1;
      end else if (i_redirect_valid) begin
         w_sel.reject_redirect = 1'b1;
      end else if (o_accept) begin
         w_sel.advance = 1'b1;
      end
   end

   // Next PC and next FSM state for every state.
   always_comb begin
      o_next_pc    = i_pc;
      o_next_state = i_state;
      o_misalign   = 1'b0;
      case (i_state)
         PC_BOOT: begin
            o_next_state = PC_RUN;
         end
         PC_RUN: begin
            if (w_sel.take_trap) begin
               o_next_pc = w_trap_pc;
            end else if (w_sel.take_redirect) begin
               o_next_pc = i_redirect_target;
            end else if (w_sel.advance) begin
               o_next_pc = w_seq_pc;
            end
            // A rejected target parks the core; halt_req loses only to a trap.
            if (w_sel.reject_redirect) begin
               o_next_state = PC_HALT;
               o_misalign   = 1'b1;
            end else if (!i_trap_valid && i_halt_req) begin
               o_next_state = PC_HALT;
            end
         end
         PC_HALT: begin
            if (i_trap_valid) begin
               o_next_pc    = w_trap_pc;
               o_next_state = PC_RUN;
            end else if (i_resume) begin
               o_next_state = PC_RUN;
            end else if (i_redirect_valid && !w_redir_bad) begin
               o_next_pc = i_redirect_target;
            end
         end
         default: begin
            // Unused encoding: fall back to a clean boot.
            o_next_state = PC_BOOT;
         end
      endcase
   end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with halt/resume, misalign detection and fetch counter (macro PC_COMPRESSED_EN)
module pc_unit
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              CNT_W        = 32
) (
   input  logic              clk,
   input  logic              res,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_target,
   input  logic              trap_valid,
   input  logic [XLEN-1:0]   trap_vector,
   input  logic              halt_req,
   input  logic              resume,
`ifdef PC_COMPRESSED_EN
   input  logic              fetch_is_c,
`endif
   input  logic              fetch_ready,
   output logic              fetch_valid,
   output logic [XLEN-1:0]   fetch_pc,
   output logic              misalign_err,
   output logic [CNT_W-1:0]  fetch_count,
   output logic [1:0]        pc_state
);

   logic [XLEN-1:0]  r_pc;
   logic [1:0]       r_state;
   logic             r_misalign;
   logic [CNT_W-1:0] r_count;

   logic [XLEN-1:0]  w_next_pc;
   logic [1:0]       w_next_state;
   logic             w_misalign;
   logic             w_accept;
   logic             w_fetch_valid;
   logic             w_is_c;

`ifdef PC_COMPRESSED_EN
   assign w_is_c = fetch_is_c;
`else
   assign w_is_c = 1'b0;
`endif

   pc_next_sel #(
      .XLEN (XLEN)
   ) u_next_sel (
      .i_state           (r_state),
      .i_pc              (r_pc),
      .i_stall           (stall),
      .i_fetch_ready     (fetch_ready),
      .i_redirect_valid  (redirect_valid),
      .i_redirect_target (redirect_target),
      .i_trap_valid      (trap_valid),
      .i_trap_vector     (trap_vector),
      .i_halt_req        (halt_req),
      .i_resume          (resume),
      .i_is_c            (w_is_c),
      .o_fetch_valid     (w_fetch_valid),
      .o_accept          (w_accept),
      .o_next_pc         (w_next_pc),
      .o_next_state      (w_next_state),
      .o_misalign        (w_misalign)
   );

   // PC, FSM state and the one-cycle misalign pulse; reset wins over everything.
   always_ff @(posedge clk) begin
      if (res) begin
         r_pc       <= RESET_VECTOR;
         r_state    <= PC_BOOT;
         r_misalign <= 1'b0;
      end else begin
         r_pc       <= w_next_pc;
         r_state    <= w_next_state;
         r_misalign <= w_misalign;
      end
   end

   // Completed-handshake counter; counts even when the PC is overridden.
   always_ff @(posedge clk) begin
      if (res) begin
         r_count <= '0;
      end else if (w_accept) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign fetch_valid  = w_fetch_valid;
   assign fetch_pc     = r_pc;
   assign misalign_err = r_misalign;
   assign fetch_count  = r_count;
   assign pc_state     = r_state;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - randomized and directed self-checking bench for pc_unit (macro PC_COMPRESSED_EN)
module tb_pc_unit;

   localparam int          XLEN  = 32;
   localparam int          CNT_W = 4;
   localparam logic [31:0] RV    = 32'h0000_0000;
`ifdef PC_COMPRESSED_EN
   localparam int unsigned ALIGN = 2;
`else
   localparam int unsigned ALIGN = 4;
`endif

   logic             clk = 1'b0;
   logic             res;
   logic             stall;
   logic             redirect_valid;
   logic [31:0]      redirect_target;
   logic             trap_valid;
   logic [31:0]      trap_vector;
   logic             halt_req;
   logic             resume;
   logic             fetch_ready;
   logic             fetch_is_c;
   logic             fetch_valid;
   logic [31:0]      fetch_pc;
   logic             misalign_err;
   logic [CNT_W-1:0] fetch_count;
   logic [1:0]       pc_state;

   int n_checks = 0;
   int n_errors = 0;

   int unsigned m_pc;
   int          m_state;
   bit          m_err;
   int          m_cnt;
   bit          armed = 1'b0;

   pc_unit #(
      .XLEN         (XLEN),
      .RESET_VECTOR (RV),
      .CNT_W        (CNT_W)
   ) dut (
      .clk             (clk),
      .res             (res),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .trap_vector     (trap_vector),
      .halt_req        (halt_req),
      .resume          (resume),
`ifdef PC_COMPRESSED_EN
      .fetch_is_c      (fetch_is_c),
`endif
      .fetch_ready     (fetch_ready),
      .fetch_valid     (fetch_valid),
      .fetch_pc        (fetch_pc),
      .misalign_err    (misalign_err),
      .fetch_count     (fetch_count),
      .pc_state        (pc_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned step_bytes();
`ifdef PC_COMPRESSED_EN
      return fetch_is_c ? 2 : 4;
`else
      return 4;
`endif
   endfunction

   // Reference behaviour: one clock edge worth of architectural effect.
   task automatic model_update();
      bit          acc;
      bit          good;
      int unsigned tvec;
      if (res) begin
         m_pc = RV; m_state = 0; m_err = 0; m_cnt = 0; armed = 1'b1;
         return;
      end
      acc  = (m_state == 1) && !stall && fetch_ready;
      good = (redirect_target % ALIGN) == 0;
      tvec = trap_vector - (trap_vector % ALIGN);
      m_err = 0;
      if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         if (acc) m_cnt = (m_cnt + 1) % (1 << CNT_W);
         if (trap_valid) begin
            m_pc = tvec;
         end else if (redirect_valid && good) begin
            m_pc = redirect_target;
            if (halt_req) m_state = 2;
         end else if (redirect_valid) begin
            m_err = 1; m_state = 2;
         end else begin
            if (acc) m_pc = m_pc + step_bytes();
            if (halt_req) m_state = 2;
         end
      end else begin
         if (trap_valid) begin
            m_pc = tvec; m_state = 1;
         end else if (resume) begin
            m_state = 1;
         end else if (redirect_valid && good) begin
            m_pc = redirect_target;
         end
      end
   endtask

   task automatic compare_all();
      chk("fetch_valid",  fetch_valid,  (m_state == 1) && !stall);
      chk("fetch_pc",     fetch_pc,     m_pc);
      chk("misalign_err", misalign_err, m_err);
      chk("fetch_count",  fetch_count,  m_cnt);
      chk("pc_state",     pc_state,     m_state);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      if (armed) compare_all();
   endtask

   task automatic idle_inputs();
      res = 0; stall = 0; redirect_valid = 0; redirect_target = 0;
      trap_valid = 0; trap_vector = 0; halt_req = 0; resume = 0;
      fetch_ready = 0; fetch_is_c = 0;
   endtask

   initial begin
      idle_inputs();
      res = 1;
      // reset held two cycles
      tick(); tick();
      chk("rst_pc", fetch_pc, 32'h0);
      chk("rst_state", pc_state, 2'd0);
      chk("rst_count", fetch_count, 4'd0);
      chk("rst_err", misalign_err, 1'b0);
      res = 0;
      #1 chk("boot_fv", fetch_valid, 1'b0);
      tick();
      chk("run_fv", fetch_valid, 1'b1);
      chk("run_state", pc_state, 2'd1);
      // sequential fetch 0,4,8,12
      fetch_ready = 1;
      tick(); chk("seq_pc1", fetch_pc, 32'd4);
      tick(); chk("seq_pc2", fetch_pc, 32'd8);
      tick(); chk("seq_pc3", fetch_pc, 32'd12);
      chk("seq_cnt", fetch_count, 4'd3);
      fetch_ready = 0;
      tick(); chk("hold_pc", fetch_pc, 32'd12);
      // trap beats redirect, handshake still counted
      trap_valid = 1; trap_vector = 32'h100;
      redirect_valid = 1; redirect_target = 32'h200; fetch_ready = 1;
      tick();
      chk("trap_pc", fetch_pc, 32'h100);
      chk("trap_cnt", fetch_count, 4'd4);
      idle_inputs();
`ifndef PC_COMPRESSED_EN
      // misaligned redirect halts with a single-cycle pulse
      redirect_valid = 1; redirect_target = 32'h202;
      tick();
      chk("mis_pc", fetch_pc, 32'h100);
      chk("mis_err", misalign_err, 1'b1);
      chk("mis_state", pc_state, 2'd2);
      redirect_valid = 0;
      tick();
      chk("mis_err_clr", misalign_err, 1'b0);
      chk("halt_fv", fetch_valid, 1'b0);
      resume = 1;
      tick();
      chk("resume_state", pc_state, 2'd1);
      chk("resume_pc", fetch_pc, 32'h100);
      resume = 0;
`endif
      // wrap at top of address space
      redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
      tick(); chk("top_pc", fetch_pc, 32'hFFFF_FFFC);
      redirect_valid = 0; fetch_ready = 1;
      tick(); chk("wrap_pc", fetch_pc, 32'h0);
      chk("wrap_cnt", fetch_count, 4'd5);
      // stall blocks request, advance and count
      stall = 1;
      #1 chk("stall_fv", fetch_valid, 1'b0);
      tick();
      chk("stall_pc", fetch_pc, 32'h0);
      chk("stall_cnt", fetch_count, 4'd5);
      idle_inputs();
      // trap vector alignment bits are cleared
      trap_valid = 1; trap_vector = 32'h103;
      tick();
`ifdef PC_COMPRESSED_EN
      chk("tvec_align", fetch_pc, 32'h102);
`else
      chk("tvec_align", fetch_pc, 32'h100);
`endif
      trap_valid = 0;
      // halt request with redirect: redirect applied, then halted
      halt_req = 1; redirect_valid = 1; redirect_target = 32'h40;
      tick();
      chk("halt_redir_pc", fetch_pc, 32'h40);
      chk("halt_redir_st", pc_state, 2'd2);
      idle_inputs();
      resume = 1;
      tick();
      chk("resume2_st", pc_state, 2'd1);
      resume = 0;
`ifdef PC_COMPRESSED_EN
      redirect_valid = 1; redirect_target = 32'h10;
      tick();
      redirect_valid = 0; fetch_is_c = 1; fetch_ready = 1;
      tick();
      chk("c_step", fetch_pc, 32'h12);
      idle_inputs();
      redirect_valid = 1; redirect_target = 32'h22;
      tick();
      chk("c_redir", fetch_pc, 32'h22);
      redirect_target = 32'h21;
      tick();
      chk("c_mis_err", misalign_err, 1'b1);
      chk("c_mis_pc", fetch_pc, 32'h22);
      chk("c_mis_st", pc_state, 2'd2);
      idle_inputs();
      resume = 1;
      tick();
      resume = 0;
`endif
      // randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         res             = ($urandom_range(0, 99) == 0);
         stall           = ($urandom_range(0, 3) == 0);
         fetch_ready     = 1'($urandom_range(0, 1));
         fetch_is_c      = 1'($urandom_range(0, 1));
         trap_valid      = ($urandom_range(0, 15) == 0);
         trap_vector     = $urandom;
         redirect_valid  = ($urandom_range(0, 7) == 0);
         redirect_target = $urandom;
         if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
         if ($urandom_range(0, 15) == 0) redirect_target[31:4] = 28'hFFF_FFFF;
         halt_req        = ($urandom_range(0, 15) == 0);
         resume          = !redirect_valid && ($urandom_range(0, 3) == 0);
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
